dmemory_bytelane: RTL and testbench
===================================

Name: dmemory_bytelane

Overview:
- Parametrised successor to the CPU data memory: byte-addressed, with byte/half/word(/double) loads and stores.
- Loads sign- or zero-extend; reads and writes may issue in the same cycle, with write-first forwarding.
- Flags misaligned, out-of-range and illegal-size accesses.
- An optional post-reset clear sweep zeroes the array.
- Sits in the MEM stage between the ALU address path and the write-back mux.

Parameters:
- WIDTH, 32, data word width in bits; legal values 32 or 64.
- DEPTH, 1024, number of WIDTH-bit words.
- ADDR_W, 32, byte-address width.
- INIT_CLEAR, 1, 1 = zero every word after reset before accepting requests; 0 = no sweep.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- read_address  in  ADDR_W  load byte address.
- write_address  in  ADDR_W  store byte address.
- read_size  in  2  0=byte, 1=half, 2=word(32b), 3=double (WIDTH=64 only).
- read_unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
- write_size  in  2  same encoding as read_size.
- write_data  in  WIDTH  store data, right-aligned (low bits used).
- ready  out  1  high when requests are accepted.
- mem_data  out  WIDTH  load result, right-aligned and extended.
- read_valid  out  1  one-cycle pulse, mem_data valid.
- read_fault  out  1  one-cycle pulse, load rejected.
- write_fault  out  1  one-cycle pulse, store rejected.

Behaviour:
- Lanes and indexing
  - LANES = WIDTH/8.
  - Word index = address >> log2(LANES).
  - Lane offset = address[log2(LANES)-1:0].
- Reset
  - Outputs go to mem_data=0, read_valid=0, read_fault=0, write_fault=0.
  - Array contents are untouched by reset itself.
  - ready=0 if INIT_CLEAR=1, else ready=1 on the cycle after rst deasserts.
- FSM states: CLEAR, RUN.
  - rst forces CLEAR (INIT_CLEAR=1) or RUN (INIT_CLEAR=0).
  - CLEAR writes 0 to one word per cycle, using an index counter from 0 to DEPTH-1.
  - After word DEPTH-1 is written, the FSM goes to RUN and ready rises the next cycle. The sweep takes exactly DEPTH cycles.
  - In CLEAR, mem_read and mem_write are ignored: no fault, no valid, no array change.
  - rst asserted mid-sweep restarts the sweep at index 0.
- Request legality, checked combinationally in RUN. A request is illegal if any of:
  - size 3 with WIDTH=32;
  - offset not a multiple of the access size in bytes (misaligned);
  - word index >= DEPTH.
- Store (accepted in RUN when mem_write=1 and legal)
  - Byte enables cover lanes [offset, offset+size_bytes-1].
  - Data is shifted left by offset*8 and written on the same edge; other lanes keep their old value.
  - An illegal store leaves the array unchanged; write_fault pulses on the next cycle.
- Load (accepted in RUN when mem_read=1 and legal)
  - Latency is 1: on the next cycle read_valid=1 and mem_data holds the selected lanes, shifted down and extended.
  - Extension: read_unsigned=0 replicates the top bit of the accessed field; a full-WIDTH access is never extended.
  - An illegal load gives read_fault=1 and read_valid=0 on the next cycle; mem_data holds its previous value.
- mem_data holds its last loaded value until the next legal load.
- Simultaneous read and write
  - Both are legal and both execute.
  - If the word indices match, the load returns the post-write word: enabled lanes come from the store data, other lanes from the array.
  - Faults are evaluated independently for each side.
- Pulses: read_valid, read_fault and write_fault are high for exactly one cycle per request. Back-to-back requests give back-to-back pulses.

Test Plan:
- INIT_CLEAR=1, DEPTH=16, rst for 2 cycles -> ready low for exactly 16 cycles after release; a word read afterwards returns 0. Re-assert rst at sweep index 7 -> the sweep restarts and takes 16 more cycles.
- Store word 0x8899AABB at 0x8, then byte 0x11 at 0xA -> load word at 0x8 returns 0x8811AABB on the next cycle with read_valid=1.
- Load byte at 0xB of word 0x80000000 with read_unsigned=0 -> 0xFFFFFF80; with read_unsigned=1 -> 0x00000080. Load half at 0xA -> 0xFFFF8000.
- Half store to 0x3 -> write_fault pulses, array unchanged. Word load at DEPTH*4 -> read_fault=1, read_valid=0. read_size=3 with WIDTH=32 -> read_fault.
- Same cycle: store half 0xBEEF at 0x12 and load word at 0x10 (old word 0x01234567) -> mem_data=0xBEEF4567.
- WIDTH=64: double store 0x0123456789ABCDEF at 0x8, then byte load at 0xF with read_unsigned=1 -> 0x01.

Source files
------------

// File: rtl/dmemory_bytelane.sv
// Byte-addressed MEM-stage data memory with sub-word loads and stores, fault flags,
// write-first forwarding between same-cycle store and load, and an optional post-reset clear sweep.
module dmemory_bytelane #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 32,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] read_address,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [1:0]        read_size,
  input  logic              read_unsigned,
  input  logic [1:0]        write_size,
  input  logic [WIDTH-1:0]  write_data,
  output logic              ready,
  output logic [WIDTH-1:0]  mem_data,
  output logic              read_valid,
  output logic              read_fault,
  output logic              write_fault
);

  localparam int LANES = WIDTH / 8;
  localparam int LW    = $clog2(LANES);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [IW-1:0]     clr_idx;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              accept, clr_we;
  logic              rd_legal, wr_legal, rd_ok, rd_bad, wr_ok, wr_bad;
  logic [IW-1:0]     ridx, widx;
  logic [LANES-1:0]  wbe;
  logic [WIDTH-1:0]  wsh, merged, rword, rsh, hi, ld;
  logic [6:0]        rbits;
  logic              sgn;

  function automatic logic legal(input logic [ADDR_W-1:0] addr, input logic [1:0] size);
    logic [ADDR_W-1:0] word;
    logic [LW-1:0]     amask;
    logic              ok;
    word  = addr >> LW;
    amask = LW'((32'd1 << size) - 32'd1);
    ok    = 1'b1;
    if (size == 2'd3 && WIDTH == 32) ok = 1'b0;
    if ((addr[LW-1:0] & amask) != '0) ok = 1'b0;
    if (word >= ADDR_W'(DEPTH)) ok = 1'b0;
    return ok;
  endfunction

  assign accept   = (state == RUN) && ready;
  assign clr_we   = (state == CLEAR) && !rst;
  assign rd_legal = legal(read_address, read_size);
  assign wr_legal = legal(write_address, write_size);
  assign rd_ok    = accept && mem_read && rd_legal;
  assign rd_bad   = accept && mem_read && !rd_legal;
  assign wr_ok    = accept && mem_write && wr_legal;
  assign wr_bad   = accept && mem_write && !wr_legal;
  assign ridx     = read_address[LW +: IW];
  assign widx     = write_address[LW +: IW];

  always_comb begin
    wbe = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      wbe[l] = (l >= 32'(write_address[LW-1:0])) &&
               (l < 32'(write_address[LW-1:0]) + (32'd1 << write_size));
    end
  end

  assign wsh = write_data << {write_address[LW-1:0], 3'b000};

  always_comb begin
    merged = mem[widx];
    for (int unsigned l = 0; l < LANES; l++) begin
      if (wbe[l]) merged[l*8 +: 8] = wsh[l*8 +: 8];
    end
  end

  // A same-cycle store to the word being loaded is forwarded so the load sees post-write data.
  assign rword = (wr_ok && ridx == widx) ? merged : mem[ridx];
  assign rsh   = rword >> {read_address[LW-1:0], 3'b000};
  assign rbits = 7'd8 << read_size;
  assign hi    = {WIDTH{1'b1}} << rbits;

  always_comb begin
    case (read_size)
      2'd0:    sgn = rsh[7];
      2'd1:    sgn = rsh[15];
      2'd2:    sgn = rsh[31];
      default: sgn = rsh[WIDTH-1];
    endcase
    ld = (rsh & ~hi) | ((sgn && !read_unsigned) ? hi : '0);
  end

  always_ff @(posedge clk) begin
    if (clr_we)     mem[clr_idx] <= '0;
    else if (wr_ok) mem[widx]    <= merged;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= (INIT_CLEAR != 0) ? CLEAR : RUN;
      clr_idx     <= '0;
      ready       <= 1'b0;
      mem_data    <= '0;
      read_valid  <= 1'b0;
      read_fault  <= 1'b0;
      write_fault <= 1'b0;
    end else begin
      read_valid  <= rd_ok;
      read_fault  <= rd_bad;
      write_fault <= wr_bad;
      if (rd_ok) mem_data <= ld;
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == IW'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_dmemory_bytelane.sv
// Scoreboard bench for dmemory_bytelane: a 32-bit/16-word and a 64-bit/8-word instance
// checked against a byte-array reference model.
module tb_dmemory_bytelane;

  localparam int D0 = 16;
  localparam int D1 = 8;

  typedef struct {
    int          due;
    bit          fault;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_s [2];
  logic        wr_s [2];
  logic [31:0] ra_s [2];
  logic [31:0] wa_s [2];
  logic [1:0]  rs_s [2];
  logic [1:0]  ws_s [2];
  logic        ru_s [2];
  logic [63:0] wd_s [2];
  logic        rdy  [2];
  logic        rv   [2];
  logic        rf   [2];
  logic        wf   [2];
  logic [31:0] md0;
  logic [63:0] md1;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        rq [2][$];
  int          wq [2][$];
  logic [7:0]  mb [2][64];
  logic [63:0] lastd [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmemory_bytelane #(.WIDTH(32), .DEPTH(D0), .ADDR_W(32), .INIT_CLEAR(1)) dut0 (
    .clk(clk), .rst(rst), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
    .read_address(ra_s[0]), .write_address(wa_s[0]), .read_size(rs_s[0]),
    .read_unsigned(ru_s[0]), .write_size(ws_s[0]), .write_data(wd_s[0][31:0]),
    .ready(rdy[0]), .mem_data(md0), .read_valid(rv[0]), .read_fault(rf[0]),
    .write_fault(wf[0]));

  dmemory_bytelane #(.WIDTH(64), .DEPTH(D1), .ADDR_W(32), .INIT_CLEAR(1)) dut1 (
    .clk(clk), .rst(rst), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
    .read_address(ra_s[1]), .write_address(wa_s[1]), .read_size(rs_s[1]),
    .read_unsigned(ru_s[1]), .write_size(ws_s[1]), .write_data(wd_s[1]),
    .ready(rdy[1]), .mem_data(md1), .read_valid(rv[1]), .read_fault(rf[1]),
    .write_fault(wf[1]));

  function automatic bit m_legal(input int d, input logic [31:0] a, input logic [1:0] sz);
    int lanes = d ? 8 : 4;
    int depth = d ? D1 : D0;
    int sb    = 1 << sz;
    if (d == 0 && sz == 2'd3) return 0;
    if (a % sb != 0) return 0;
    if (a / lanes >= depth) return 0;
    return 1;
  endfunction

  function automatic logic [63:0] m_load(input int d, input logic [31:0] a,
                                         input logic [1:0] sz, input bit uns);
    logic [63:0] v = '0;
    int sb = 1 << sz;
    int nb = 8 * sb;
    int w  = d ? 64 : 32;
    for (int i = 0; i < sb; i++) v |= 64'(mb[d][a + i]) << (8 * i);
    if (!uns && nb < w && ((v >> (nb - 1)) & 64'd1) == 64'd1) v |= ~64'd0 << nb;
    if (w == 32) v &= 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic check(input string name, input int d, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h", name, d, got, want);
    end
  endtask

  task automatic mon(input int d, input bit v, input bit f, input bit w, input logic [63:0] md);
    exp_t e;
    if (v || f) begin
      if (rq[d].size() == 0 || rq[d][0].due != cyc) begin
        check("unexpected_read_pulse", d, {62'd0, v, f}, 64'd0);
      end else begin
        e = rq[d].pop_front();
        check("read_kind", d, {62'd0, v, f}, {62'd0, !e.fault, e.fault});
        check("mem_data", d, md, e.data);
      end
    end else if (rq[d].size() > 0 && rq[d][0].due == cyc) begin
      e = rq[d].pop_front();
      check("missing_read_pulse", d, 64'd0, {62'd0, !e.fault, e.fault});
    end
    if (w) begin
      if (wq[d].size() == 0 || wq[d][0] != cyc) check("unexpected_write_fault", d, 64'd1, 64'd0);
      else void'(wq[d].pop_front());
    end else if (wq[d].size() > 0 && wq[d][0] == cyc) begin
      void'(wq[d].pop_front());
      check("missing_write_fault", d, 64'd0, 64'd1);
    end
  endtask

  always @(negedge clk) begin
    mon(0, rv[0], rf[0], wf[0], {32'd0, md0});
    mon(1, rv[1], rf[1], wf[1], md1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      rd_s[d] = 1'b0;
      wr_s[d] = 1'b0;
    end
  endtask

  task automatic issue(input int d, input bit rdq, input bit wrq,
                       input logic [31:0] ra, input logic [1:0] rs, input bit ru,
                       input logic [31:0] wa, input logic [1:0] ws, input logic [63:0] wd);
    exp_t e;
    rd_s[d] = rdq; wr_s[d] = wrq;
    ra_s[d] = ra;  rs_s[d] = rs; ru_s[d] = ru;
    wa_s[d] = wa;  ws_s[d] = ws; wd_s[d] = wd;
    // Store is applied to the model first so a same-cycle load sees post-write bytes.
    if (wrq) begin
      if (m_legal(d, wa, ws)) begin
        for (int i = 0; i < (1 << ws); i++) mb[d][wa + i] = 8'(wd >> (8 * i));
      end else begin
        wq[d].push_back(cyc + 1);
      end
    end
    if (rdq) begin
      e.due = cyc + 1;
      if (m_legal(d, ra, rs)) begin
        e.fault  = 0;
        e.data   = m_load(d, ra, rs, ru);
        lastd[d] = e.data;
      end else begin
        e.fault = 1;
        e.data  = lastd[d];
      end
      rq[d].push_back(e);
    end
  endtask

  task automatic sweep_measure(input int e0, input int e1);
    int n0 = 0;
    int n1 = 0;
    for (int n = 1; n <= 64 && (n0 == 0 || n1 == 0); n++) begin
      step();
      if (rdy[0] && n0 == 0) n0 = n;
      if (rdy[1] && n1 == 0) n1 = n;
    end
    check("sweep_cycles", 0, 64'(n0), 64'(e0));
    check("sweep_cycles", 1, 64'(n1), 64'(e1));
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) mb[d][i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    for (int d = 0; d < 2; d++) lastd[d] = '0;
    check("reset_ready", 0, 64'(rdy[0]), 64'd0);
    check("reset_ready", 1, 64'(rdy[1]), 64'd0);
    check("reset_pulses", 0, {61'd0, rv[0], rf[0], wf[0]}, 64'd0);
    check("reset_pulses", 1, {61'd0, rv[1], rf[1], wf[1]}, 64'd0);
    check("reset_mem_data", 0, {32'd0, md0}, 64'd0);
    check("reset_mem_data", 1, md1, 64'd0);
    rst = 1'b0;
  endtask

  task automatic random_phase(input int iters);
    for (int k = 0; k < iters; k++) begin
      for (int d = 0; d < 2; d++) begin
        issue(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 71)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 71)), 2'($urandom_range(0, 3)), {$urandom, $urandom});
      end
      step();
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd_s[d] = 0; wr_s[d] = 0; ra_s[d] = '0; wa_s[d] = '0;
      rs_s[d] = '0; ws_s[d] = '0; ru_s[d] = 0; wd_s[d] = '0; lastd[d] = '0;
    end
    rst = 1'b1;
    #1;
    do_reset();
    sweep_measure(D0, D1);

    // Directed scenarios on the 32-bit instance.
    issue(0, 0, 1, 0, 0, 0, 32'h8, 2, 64'h8899AABB); step();
    issue(0, 0, 1, 0, 0, 0, 32'hA, 0, 64'h11);       step();
    issue(0, 1, 0, 32'h8, 2, 0, 0, 0, 0);            step();
    issue(0, 0, 1, 0, 0, 0, 32'h8, 2, 64'h80000000); step();
    issue(0, 1, 0, 32'hB, 0, 0, 0, 0, 0);            step();
    issue(0, 1, 0, 32'hB, 0, 1, 0, 0, 0);            step();
    issue(0, 1, 0, 32'hA, 1, 0, 0, 0, 0);            step();
    issue(0, 0, 1, 0, 0, 0, 32'h3, 1, 64'hDEAD);     step();
    issue(0, 1, 0, 32'h0, 2, 0, 0, 0, 0);            step();
    issue(0, 1, 0, 32'(D0 * 4), 2, 0, 0, 0, 0);      step();
    issue(0, 1, 0, 32'h0, 3, 0, 0, 0, 0);            step();
    issue(0, 0, 1, 0, 0, 0, 32'h10, 2, 64'h01234567); step();
    issue(0, 1, 1, 32'h10, 2, 0, 32'h12, 1, 64'hBEEF); step();
    // Directed scenarios on the 64-bit instance.
    issue(1, 0, 1, 0, 0, 0, 32'h8, 3, 64'h0123456789ABCDEF); step();
    issue(1, 1, 0, 32'hF, 0, 1, 0, 0, 0);            step();
    issue(1, 1, 0, 32'h8, 3, 0, 0, 0, 0);            step();
    issue(1, 1, 0, 32'hC, 2, 0, 0, 0, 0);            step();

    random_phase(300);

    // Mid-sweep reset restarts the clear; requests during the sweep must be ignored.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      for (int d = 0; d < 2; d++) begin
        rd_s[d] = 1; wr_s[d] = 1; ra_s[d] = 32'h3; rs_s[d] = 2; wa_s[d] = 32'h4;
        ws_s[d] = 2; wd_s[d] = {$urandom, $urandom};
      end
      step();
      check("ready_in_sweep", 0, 64'(rdy[0]), 64'd0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    sweep_measure(D0, D1);
    for (int i = 0; i < D0; i++) begin issue(0, 1, 0, 32'(i * 4), 2, 0, 0, 0, 0); step(); end
    for (int i = 0; i < D1; i++) begin issue(1, 1, 0, 32'(i * 8), 3, 0, 0, 0, 0); step(); end

    random_phase(200);
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      check("drain_reads", d, 64'(rq[d].size()), 64'd0);
      check("drain_write_faults", d, 64'(wq[d].size()), 64'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
